// File: rtl/led_rotation_monitor_pkg.sv
// Shared constants for the LED shifter and its receive-side rotation monitor.
package led_pkg;

  localparam int unsigned     LED_WIDTH      = 8;
  localparam logic [7:0]      LED_SEED       = 8'b0001_1111;
  localparam int unsigned     LED_HOLD       = 2;
  localparam int unsigned     LED_LOCK_COUNT = 4;
  localparam int unsigned     LED_ERR_CNT_W  = 16;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } led_state_e;

endpackage

// File: rtl/led_rotation_monitor_if.sv
// Pattern bus plus monitor status outputs; master drives the pattern, slave is the monitor.
interface led_rotation_monitor_if
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = LED_WIDTH
);

  logic [WIDTH-1:0]         pat_i;
  logic                     step_o;
  logic [$clog2(WIDTH)-1:0] phase_o;
  logic                     lock_o;
  logic                     err_o;
  logic [LED_ERR_CNT_W-1:0] err_cnt_o;

  modport master (
    output pat_i,
    input  step_o, phase_o, lock_o, err_o, err_cnt_o
  );

  modport slave (
    input  pat_i,
    output step_o, phase_o, lock_o, err_o, err_cnt_o
  );

endinterface

// File: rtl/led_rotation_monitor_rot_phase_decoder.sv
// Combinational decode of k such that pat == rotl(SEED, k); lowest k wins, valid=0 if none.
module rot_phase_decoder
  import led_pkg::*;
#(
  parameter int unsigned     WIDTH = LED_WIDTH,
  parameter logic [WIDTH-1:0] SEED = LED_SEED
) (
  input  logic [WIDTH-1:0]         pat,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     valid
);

  localparam int unsigned PW = $clog2(WIDTH);

  logic [WIDTH-1:0] rot;

  always_comb begin
    phase = '0;
    valid = 1'b0;
    rot   = SEED;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (!valid && (pat == rot)) begin
        valid = 1'b1;
        phase = PW'(k);
      end
      rot = {rot[WIDTH-2:0], rot[WIDTH-1]};
    end
  end

endmodule

// File: rtl/led_rotation_monitor.sv
// Locks onto the rotate-left LED sequence and reports step, phase, lock and protocol errors.
// Optional saturating error counter enabled by defining LEDMON_ERR_COUNT_EN.
module led_rotation_monitor
  import led_pkg::*;
#(
  parameter int unsigned      WIDTH       = LED_WIDTH,
  parameter logic [WIDTH-1:0] SEED        = LED_SEED,
  parameter int unsigned      HOLD_CYCLES = LED_HOLD,
  parameter int unsigned      LOCK_COUNT  = LED_LOCK_COUNT
) (
  input  logic                  clk,
  input  logic                  rst,
  led_rotation_monitor_if.slave mon
);

  localparam int unsigned PW  = $clog2(WIDTH);
  localparam int unsigned HCW = $clog2(HOLD_CYCLES + 2);
  localparam int unsigned GCW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] S_SEARCH  = SEARCH;
  localparam logic [1:0] S_ACQUIRE = ACQUIRE;
  localparam logic [1:0] S_LOCKED  = LOCKED;

  logic [WIDTH-1:0] pat_q,      pat_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [GCW-1:0]   good_cnt_q, good_cnt_d;
  logic [1:0]       state_q,    state_d;
  logic             step_q,     step_d;
  logic [PW-1:0]    phase_q,    phase_d;
  logic             lock_q,     lock_d;
  logic             err_q,      err_d;

  logic [PW-1:0]    dec_phase_c;
  logic             dec_valid_c;
  logic             chg_c;
  logic             hold_done_c;
  logic             good_c;
  logic             bad_c;

  rot_phase_decoder #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_dec (
    .pat   (mon.pat_i),
    .phase (dec_phase_c),
    .valid (dec_valid_c)
  );

  // Step qualification: a change must be a left rotate arriving exactly HOLD_CYCLES after the last one.
  always_comb begin
    chg_c       = (mon.pat_i != pat_q);
    hold_done_c = (hold_cnt_q == HCW'(HOLD_CYCLES));
    good_c      = chg_c && (mon.pat_i == {pat_q[WIDTH-2:0], pat_q[WIDTH-1]}) && hold_done_c;
    bad_c       = (chg_c && !good_c) || (!chg_c && hold_done_c);
  end

  always_comb begin
    pat_d = mon.pat_i;
    if (chg_c) begin
      hold_cnt_d = HCW'(1);
    end else if (hold_cnt_q == HCW'(HOLD_CYCLES + 1)) begin
      hold_cnt_d = hold_cnt_q;
    end else begin
      hold_cnt_d = hold_cnt_q + HCW'(1);
    end
  end

  // Tracking FSM; a bad step always drops to SEARCH even if the new value decodes.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    phase_d    = phase_q;

    case (state_q)
      S_SEARCH: begin
        if (chg_c && dec_valid_c) begin
          state_d    = S_ACQUIRE;
          good_cnt_d = '0;
          phase_d    = dec_phase_c;
        end
      end
      S_ACQUIRE: begin
        if (bad_c) begin
          state_d = S_SEARCH;
        end else if (good_c) begin
          step_d     = 1'b1;
          phase_d    = dec_phase_c;
          good_cnt_d = good_cnt_q + GCW'(1);
          if (good_cnt_d == GCW'(LOCK_COUNT)) begin
            state_d = S_LOCKED;
          end
        end
      end
      S_LOCKED: begin
        if (bad_c) begin
          state_d = S_SEARCH;
          err_d   = 1'b1;
        end else if (good_c) begin
          step_d  = 1'b1;
          phase_d = dec_phase_c;
        end
      end
      default: begin
        state_d = S_SEARCH;
      end
    endcase

    lock_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q      <= '0;
      hold_cnt_q <= '0;
      good_cnt_q <= '0;
      state_q    <= S_SEARCH;
      step_q     <= 1'b0;
      phase_q    <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      hold_cnt_q <= hold_cnt_d;
      good_cnt_q <= good_cnt_d;
      state_q    <= state_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
    end
  end

  assign mon.step_o  = step_q;
  assign mon.phase_o = phase_q;
  assign mon.lock_o  = lock_q;
  assign mon.err_o   = err_q;

`ifdef LEDMON_ERR_COUNT_EN
  logic [LED_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts alongside the err_o pulse and sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != {LED_ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + LED_ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign mon.err_cnt_o = err_cnt_q;
`else
  assign mon.err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_led_rotation_monitor.sv
// Randomized and directed bench for led_rotation_monitor against a behavioural tracking model.
module tb_led_rotation_monitor;
  import led_pkg::*;

  localparam int SEED_I = 31;
  localparam int HOLD_I = 2;
  localparam int LOCK_I = 4;

  logic clk;
  logic rst;

  led_rotation_monitor_if #(.WIDTH(LED_WIDTH)) mon_if ();

  led_rotation_monitor dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // model state: last seen value, cycles it has been seen, tracking/locked, good steps while acquiring
  int m_prev, m_run, m_goods;
  bit m_track, m_locked;
  int e_step, e_phase, e_lock, e_err, e_cnt;

  int src_val, src_cnt;
  int saw_lock, saw_err;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rotl1(input int v);
    return ((v << 1) | (v >> 7)) & 255;
  endfunction

  function automatic int rotr1(input int v);
    return ((v >> 1) | (v << 7)) & 255;
  endfunction

  function automatic int phase_of(input int v);
    for (int k = 0; k < 8; k++) begin
      if ((((SEED_I << k) | (SEED_I >> (8 - k))) & 255) == v) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input int v, input bit r);
    bit chg, good, bad;
    if (r) begin
      m_prev = 0; m_run = 0; m_goods = 0; m_track = 0; m_locked = 0;
      e_step = 0; e_phase = 0; e_lock = 0; e_err = 0; e_cnt = 0;
      return;
    end
    chg  = (v != m_prev);
    good = chg && (v == rotl1(m_prev)) && (m_run == HOLD_I);
    bad  = (chg && !good) || (!chg && m_run == HOLD_I);
    e_step = 0;
    e_err  = 0;
    if (!m_track) begin
      if (chg && phase_of(v) >= 0) begin
        m_track = 1; m_goods = 0; e_phase = phase_of(v);
      end
    end else if (bad) begin
      if (m_locked) begin
        e_err = 1;
        if (e_cnt < 65535) e_cnt++;
      end
      m_track = 0; m_locked = 0;
    end else if (good) begin
      e_step = 1;
      e_phase = phase_of(v);
      if (!m_locked) begin
        m_goods++;
        if (m_goods == LOCK_I) m_locked = 1;
      end
    end
    e_lock = m_locked ? 1 : 0;
    m_run  = chg ? 1 : ((m_run < HOLD_I + 1) ? m_run + 1 : m_run);
    m_prev = v;
  endtask

  task automatic tick(input int v, input bit r);
    int exp_cnt;
    model_step(v, r);
    mon_if.pat_i = 8'(v);
    rst = r;
    @(posedge clk);
    #1;
`ifdef LEDMON_ERR_COUNT_EN
    exp_cnt = e_cnt;
`else
    exp_cnt = 0;
`endif
    check("step",    int'(mon_if.step_o),    e_step);
    check("phase",   int'(mon_if.phase_o),   e_phase);
    check("lock",    int'(mon_if.lock_o),    e_lock);
    check("err",     int'(mon_if.err_o),     e_err);
    check("err_cnt", int'(mon_if.err_cnt_o), exp_cnt);
    if (mon_if.lock_o) saw_lock++;
    if (mon_if.err_o)  saw_err++;
  endtask

  task automatic src_tick(input int hold, input bit right);
    tick(src_val, 1'b0);
    src_cnt++;
    if (src_cnt >= hold) begin
      src_cnt = 0;
      src_val = right ? rotr1(src_val) : rotl1(src_val);
    end
  endtask

  task automatic src_restart();
    src_val = SEED_I;
    src_cnt = 0;
  endtask

  initial begin
    int r;
    n_tests = 0;
    n_fail  = 0;
    saw_lock = 0;
    saw_err  = 0;
    rst = 1'b1;
    mon_if.pat_i = '0;
    #1;

    tick(0, 1'b1);
    tick(0, 1'b1);

    // normal shifter after reset: lock, steps, phase wrap
    src_restart();
    repeat (24) src_tick(HOLD_I, 1'b0);

    // freeze for 3 cycles while locked, then relock
    repeat (3) tick(src_val, 1'b0);
    repeat (16) src_tick(HOLD_I, 1'b0);

    // one-cycle 0x00 glitch while locked
    tick(0, 1'b0);
    repeat (16) src_tick(HOLD_I, 1'b0);

    // source speeds up to hold 1
    repeat (4) src_tick(1, 1'b0);
    repeat (16) src_tick(HOLD_I, 1'b0);

    // one-cycle reset while locked, then relock
    tick(src_val, 1'b1);
    repeat (16) src_tick(HOLD_I, 1'b0);

    // rotate-right source never locks and never errors
    tick(0, 1'b1);
    src_restart();
    saw_lock = 0;
    saw_err  = 0;
    repeat (100) src_tick(HOLD_I, 1'b1);
    check("rotr_lock_seen", saw_lock, 0);
    check("rotr_err_seen",  saw_err,  0);

    // randomized disturbances on top of a good source
    tick(0, 1'b1);
    src_restart();
    repeat (3000) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       tick(int'($urandom_range(0, 255)), 1'b0);
      else if (r < 4)  tick(src_val, 1'b0);
      else if (r < 5)  src_tick(1, 1'b0);
      else if (r < 6)  tick(src_val, 1'b1);
      else if (r < 7)  src_tick(HOLD_I, 1'b1);
      else             src_tick(HOLD_I, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
